// File: rtl/module_scan_tecladohex.sv
// 4x4 hex keypad scanner with synchronised columns, press/release debounce and one-cycle key event; KEY_REPEAT_EN adds auto-repeat.
// States: SCAN=rotate rows | DEB_PRESS=confirm single-column press | PRESSED=key held | DEB_REL=confirm release.
module module_scan_tecladohex #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_CYCLES   = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] fila_out,
  output logic [3:0] key_fila,
  output logic [3:0] key_col,
  output logic       key_valid,
  output logic       key_held
);

  localparam int TW = $clog2(SCAN_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_REL} state_t;

  state_t        r_state;
  logic [3:0]    r_sync1;
  logic [3:0]    r_col_s;
  logic [3:0]    r_fila;
  logic [3:0]    r_cap_col;
  logic [3:0]    r_cap_fila;
  logic [TW-1:0] r_timer;
  logic [DW-1:0] r_deb_cnt;
  logic          w_one_hot;
  logic          w_rep_hit;

  assign fila_out  = r_fila;
  assign w_one_hot = (r_col_s != 4'd0) && ((r_col_s & (r_col_s - 4'd1)) == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 4'd0;
      r_col_s <= 4'd0;
    end else begin
      r_sync1 <= col_in;
      r_col_s <= r_sync1;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] r_rep_cnt;

  assign w_rep_hit = (r_state == PRESSED) && (r_col_s != 4'd0) && (r_rep_cnt == REP_LAST);

  // Held at zero outside PRESSED, so both entry paths into PRESSED restart the period.
  always_ff @(posedge clk) begin
    if (!rst_n || r_state != PRESSED || r_col_s == 4'd0 || w_rep_hit)
      r_rep_cnt <= '0;
    else
      r_rep_cnt <= r_rep_cnt + 1'b1;
  end
`else
  // Repeat is compiled out; REPEAT_CYCLES < 1 is not a legal configuration.
  assign w_rep_hit = (REPEAT_CYCLES < 1);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= SCAN;
      r_fila     <= 4'b0001;
      r_timer    <= '0;
      r_deb_cnt  <= '0;
      r_cap_col  <= 4'd0;
      r_cap_fila <= 4'd0;
      key_fila   <= 4'd0;
      key_col    <= 4'd0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (r_state)
        SCAN: begin
          if (r_timer == TIMER_LAST) begin
            r_timer <= '0;
            if (w_one_hot) begin
              r_cap_col  <= r_col_s;
              r_cap_fila <= r_fila;
              r_deb_cnt  <= '0;
              r_state    <= DEB_PRESS;
            end else begin
              r_fila <= {r_fila[2:0], r_fila[3]};
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        DEB_PRESS: begin
          if (r_col_s != r_cap_col) begin
            r_fila  <= {r_fila[2:0], r_fila[3]};
            r_timer <= '0;
            r_state <= SCAN;
          end else if (r_deb_cnt == DEB_LAST) begin
            key_fila  <= r_cap_fila;
            key_col   <= r_cap_col;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            r_state   <= PRESSED;
          end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (r_col_s == 4'd0) begin
            r_deb_cnt <= '0;
            r_state   <= DEB_REL;
          end else if (w_rep_hit) begin
            key_valid <= 1'b1;
          end
        end
        DEB_REL: begin
          if (r_col_s != 4'd0) begin
            r_state <= PRESSED;
          end else if (r_deb_cnt == DEB_LAST) begin
            key_held <= 1'b0;
            r_fila   <= {r_fila[2:0], r_fila[3]};
            r_timer  <= '0;
            r_state  <= SCAN;
          end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_module_scan_tecladohex.sv
// Self-checking bench for module_scan_tecladohex: keypad model, expected-event queue and key_valid monitor.
`timescale 1ns/1ps
module tb_module_scan_tecladohex;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int REP      = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col_in;
  logic [3:0] fila_out, key_fila, key_col;
  logic       key_valid, key_held;

  always #5 clk = ~clk;

  module_scan_tecladohex #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .col_in(col_in), .fila_out(fila_out),
    .key_fila(key_fila), .key_col(key_col), .key_valid(key_valid), .key_held(key_held)
  );

  // Keypad: one switch at (key_r, key_c) connects its row line to its column line.
  logic       key_on = 1'b0;
  int         key_r = 0, key_c = 0;
  logic [3:0] ghost_mask = 4'd0;

  always_comb begin
    col_in = 4'd0;
    if (key_on && fila_out[key_r]) col_in = 4'b0001 << key_c;
    if (fila_out == 4'b0001) col_in = col_in | ghost_mask;
  end

  typedef struct packed { logic [3:0] fila; logic [3:0] col; } exp_t;
  exp_t exp_q[$];
  int   pulse_cyc[$];
  int   n_cmp = 0, n_err = 0, cyc = 0, n_pulse = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    return 4'b0001 << i;
  endfunction

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_n && key_valid) begin
      exp_t e;
      n_pulse++;
      pulse_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("ev_key_fila", key_fila, e.fila);
        chk("ev_key_col", key_col, e.col);
        chk("ev_key_held", key_held, 1);
        chk("ev_fila_out", fila_out, e.fila);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_accept(input int r, input int c, input bit bounce);
    exp_t e;
    e.fila = oh(r);
    e.col  = oh(c);
    exp_q.push_back(e);
    key_r = r;
    key_c = c;
    if (bounce) begin
      for (int i = 0; i < 3; i++) begin
        key_on = ~key_on;
        tick();
      end
    end
    key_on = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    chk("accept_pending", exp_q.size(), 0);
    chk("held_after_accept", key_held, 1);
    chk("fila_frozen", fila_out, oh(r));
  endtask

  task automatic release_key(input int r);
    key_on = 1'b0;
    for (int i = 0; i < 100 && key_held; i++) tick();
    chk("release_held", key_held, 0);
    chk("resume_row", fila_out, oh((r + 1) % 4));
  endtask

  initial begin
    int p0, a, sz, changes, k;
    logic [3:0] prev, nxt;

    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_fila_out", fila_out, 4'b0001);
    chk("rst_key_fila", key_fila, 0);
    chk("rst_key_col", key_col, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_held", key_held, 0);
    rst_n = 1'b1;

    // key "5"
    press_accept(1, 1, 1'b0);
    repeat (10) tick();
    chk("five_fila_hold", fila_out, 4'b0010);
    release_key(1);

    // key "#" with bounce, then short release and re-press
    p0 = n_pulse;
    press_accept(3, 2, 1'b1);
    chk("bounce_pulses", n_pulse - p0, 1);
    key_on = 1'b0;
    repeat (5) tick();
    key_on = 1'b1;
    repeat (15) tick();
    chk("short_release_held", key_held, 1);
    chk("short_release_pulses", n_pulse - p0, 1);
    release_key(3);

    // ghost: two columns on row 0
    ghost_mask = 4'b0011;
    p0 = n_pulse;
    changes = 0;
    prev = fila_out;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (fila_out != prev) begin
        nxt = {prev[2:0], prev[3]};
        chk("ghost_rotate", fila_out, nxt);
        changes++;
        prev = fila_out;
      end
    end
    chk("ghost_rotations", changes >= 4, 1);
    chk("ghost_pulses", n_pulse - p0, 0);
    ghost_mask = 4'd0;

    for (int n = 0; n < 8; n++) begin
      k = $urandom_range(0, 15);
      press_accept(k / 4, k % 4, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 20)) tick();
      release_key(k / 4);
    end

    // long hold: 100 cycles past acceptance
    p0 = n_pulse;
    press_accept(2, 0, 1'b0);
    a = pulse_cyc[pulse_cyc.size() - 1];
`ifdef KEY_REPEAT_EN
    for (int i = 0; i < 3; i++) exp_q.push_back({oh(2), oh(0)});
`endif
    for (int i = 0; i < 200 && cyc < a + 100; i++) tick();
`ifdef KEY_REPEAT_EN
    chk("repeat_pending", exp_q.size(), 0);
    chk("repeat_count", n_pulse - p0, 4);
    sz = pulse_cyc.size();
    for (int i = 1; i <= 3; i++)
      chk("repeat_gap", pulse_cyc[sz - i] - pulse_cyc[sz - i - 1], REP);
`else
    chk("no_repeat_count", n_pulse - p0, 1);
`endif
    release_key(2);

    // reset while PRESSED
    press_accept(0, 3, 1'b0);
    repeat (5) tick();
    rst_n = 1'b0;
    key_on = 1'b0;
    tick();
    chk("mid_rst_fila_out", fila_out, 4'b0001);
    chk("mid_rst_key_fila", key_fila, 0);
    chk("mid_rst_key_col", key_col, 0);
    chk("mid_rst_key_valid", key_valid, 0);
    chk("mid_rst_key_held", key_held, 0);
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    chk("post_rst_held", key_held, 0);

    chk("queue_empty_end", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
